tracking_fifo_sc: RTL and testbench

Single-clock, parametrised successor to the dual-clock tracking FIFO used by the cosim firmware.
- Buffers WIDTH-bit words in a 2^ADDR_WIDTH-entry register array.
- Exports its write/read addresses for host-side tracking.
- Adds what the earlier block lacked: an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Sits between the host interface and the converter datapath, as the earlier block did.

---
 rtl/tracking_fifo_sc.sv | 169 ++++++++++++++++
 tb/tb_tracking_fifo_sc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tracking_fifo_sc.sv
// tracking_fifo_sc
// ----------------
// Single-clock FIFO of 2^ADDR_WIDTH words of WIDTH bits. Every entry is usable.
// The write and read addresses are exported so the host can track the buffer.
// It also provides an occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a synchronous flush.
//
// Build option:
//   TRACKING_FIFO_SC_FWFT_EN
//     Defined   : first-word-fall-through. data_out is a combinational view of
//                 the entry at addr_out and is valid whenever empty = 0.
//     Undefined : data_out is registered and updates one cycle after an
//                 accepted read. It holds its value otherwise.
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   synchronous active-high reset (takes priority over flush)
//   data_in       in   write data
//   write_in      in   write request
//   data_out      out  read data
//   read_out      in   read request
//   flush         in   synchronous clear of contents and error flags
//   addr_in       out  current write address (low bits of write pointer)
//   addr_out      out  current read address (low bits of read pointer)
//   count         out  occupancy, 0..DEPTH
//   full, empty   out  count == DEPTH / count == 0
//   almost_full   out  count >= AFULL_THRESH
//   almost_empty  out  count <= AEMPTY_THRESH
//   overflow      out  sticky: write attempted while full (no read on that edge)
//   underflow     out  sticky: read attempted while empty
module tracking_fifo_sc #(
  parameter int WIDTH         = 8,
  parameter int ADDR_WIDTH    = 11,
  parameter int AFULL_THRESH  = 2044,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  write_in,
  output logic [WIDTH-1:0]      data_out,
  input  logic                  read_out,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_CNT    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = AEMPTY_THRESH[ADDR_WIDTH:0];

  // Thresholds must lie inside the occupancy range or the decodes are meaningless.
  if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH >= DEPTH) begin : g_bad_thresh
    $error("tracking_fifo_sc: AFULL_THRESH must be 0..DEPTH and AEMPTY_THRESH 0..DEPTH-1");
  end

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_reg;
  logic [ADDR_WIDTH:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0] count_reg;
  logic [ADDR_WIDTH:0] count_next;
  logic                overflow_reg;
  logic                underflow_reg;

  logic                wr_accept;
  logic                rd_accept;
  logic                mem_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign wr_addr = wr_ptr_reg[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_reg[ADDR_WIDTH-1:0];

  // Status is decoded from the registered count only.
  assign full         = (count_reg == DEPTH_CNT);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AFULL_CNT);
  assign almost_empty = (count_reg <= AEMPTY_CNT);

  // A read frees a slot on the same edge, so a write into a full FIFO is
  // still accepted when a read is accepted alongside it.
  assign rd_accept = read_out & ~empty;
  assign wr_accept = write_in & (~full | rd_accept);
  assign mem_we    = wr_accept & ~flush & ~reset;

  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + ONE_CNT;
      2'b01:   count_next = count_reg - ONE_CNT;
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset so that it can map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + ONE_CNT;
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + ONE_CNT;
      end
      count_reg <= count_next;
      if (write_in && !wr_accept) begin
        overflow_reg <= 1'b1;
      end
      if (read_out && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

`ifdef TRACKING_FIFO_SC_FWFT_EN
  // The head entry is always presented. When the FIFO is full, a simultaneous
  // write targets the head slot. That write only lands at the edge, so the
  // popped word is still the old one.
  assign data_out = mem[rd_addr];
`else
  logic [WIDTH-1:0] data_out_reg;

  // Registered read: the word appears the cycle after the accepting edge.
  // Flush leaves the last read word visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_reg <= '0;
    end else if (!flush && rd_accept) begin
      data_out_reg <= mem[rd_addr];
    end
  end

  assign data_out = data_out_reg;
`endif

  assign addr_in   = wr_addr;
  assign addr_out  = rd_addr;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_tracking_fifo_sc.sv
module tb_tracking_fifo_sc;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       write_in;
  logic [7:0] data_out;
  logic       read_out;
  logic       flush;
  logic [3:0] addr_in;
  logic [3:0] addr_out;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       rd_expect;

  tracking_fifo_sc #(
    .WIDTH(8),
    .ADDR_WIDTH(4),
    .AFULL_THRESH(14),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .write_in(write_in),
    .data_out(data_out),
    .read_out(read_out),
    .flush(flush),
    .addr_in(addr_in),
    .addr_out(addr_out),
    .count(count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic compare_read();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL read_data actual=%0h required=<none queued>", data_out);
    end else begin
      e = exp_q.pop_front();
      check("read_data", {24'd0, data_out}, {24'd0, e});
    end
  endtask

  // Monitor: compares data_out against the scoreboard whenever a read was issued.
`ifdef TRACKING_FIFO_SC_FWFT_EN
  initial forever begin
    @(negedge clk);
    if (rd_expect) compare_read();
  end
`else
  initial forever begin
    @(posedge clk);
    if (rd_expect) begin
      @(negedge clk);
      compare_read();
    end
  end
`endif

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus. r_ok is the hand-computed acceptance of the read.
  task automatic op(input bit w, input logic [7:0] d, input bit r, input bit r_ok,
                    input logic [7:0] exp);
    write_in  = w;
    data_in   = d;
    read_out  = r;
    rd_expect = r & r_ok;
    if (r && r_ok) exp_q.push_back(exp);
    tick();
    write_in  = 1'b0;
    read_out  = 1'b0;
    rd_expect = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; write_in = 1'b0; read_out = 1'b0;
    data_in = 8'h00; rd_expect = 1'b0;
    #1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_aempty", {31'd0, almost_empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_afull", {31'd0, almost_full}, 32'd0);
    check("rst_addr_in", {28'd0, addr_in}, 32'd0);
    check("rst_addr_out", {28'd0, addr_out}, 32'd0);
    check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
`ifndef TRACKING_FIFO_SC_FWFT_EN
    check("rst_data_out", {24'd0, data_out}, 32'd0);
`endif

    // Fill / drain
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
      check("fill_count", {27'd0, count}, i + 1);
      check("fill_afull", {31'd0, almost_full}, (i + 1 >= 14) ? 32'd1 : 32'd0);
      check("fill_aempty", {31'd0, almost_empty}, (i + 1 <= 2) ? 32'd1 : 32'd0);
      check("fill_full", {31'd0, full}, (i + 1 == 16) ? 32'd1 : 32'd0);
    end
    check("fill_addr_in", {28'd0, addr_in}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
      check("drain_count", {27'd0, count}, 15 - i);
    end
    tick();
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_addr_out", {28'd0, addr_out}, 32'd0);

    // Overflow
    for (int i = 0; i < 16; i++) op(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 8'h00);
    op(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_count", {27'd0, count}, 32'd16);
    check("ovf_addr_in", {28'd0, addr_in}, 32'd0);
    for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1, 1'b1, 8'h10 + 8'(i));
    tick();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_empty", {31'd0, empty}, 32'd1);

    // Flush clears flags, keeps data_out
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush1_flags", {30'd0, overflow, underflow}, 32'd0);
`ifndef TRACKING_FIFO_SC_FWFT_EN
    check("flush1_data_hold", {24'd0, data_out}, 32'h1F);
`endif

    // Read on empty alone
    op(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("udf_flag", {31'd0, underflow}, 32'd1);
    check("udf_count", {27'd0, count}, 32'd0);
    check("udf_addr_out", {28'd0, addr_out}, 32'd0);
`ifndef TRACKING_FIFO_SC_FWFT_EN
    check("udf_data_hold", {24'd0, data_out}, 32'h1F);
`endif
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush2_udf", {31'd0, underflow}, 32'd0);

    // Underflow with simultaneous write
    op(1'b1, 8'h55, 1'b1, 1'b0, 8'h00);
    check("udfw_flag", {31'd0, underflow}, 32'd1);
    check("udfw_count", {27'd0, count}, 32'd1);
    check("udfw_addr_in", {28'd0, addr_in}, 32'd1);
    op(1'b0, 8'h00, 1'b1, 1'b1, 8'h55);
    check("udfw_count2", {27'd0, count}, 32'd0);

    // Wrap with simultaneous read+write at count 8
    for (int i = 0; i < 8; i++) op(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 40; i++) begin
      op(1'b1, 8'h88 + 8'(i), 1'b1, 1'b1, 8'h80 + 8'(i));
      if (count !== 5'd8) check("wrap_count", {27'd0, count}, 32'd8);
    end
    check("wrap_count_end", {27'd0, count}, 32'd8);
    check("wrap_addr_in", {28'd0, addr_in}, 32'd1);
    check("wrap_addr_out", {28'd0, addr_out}, 32'd9);
    for (int i = 0; i < 8; i++) op(1'b0, 8'h00, 1'b1, 1'b1, 8'hA8 + 8'(i));
    check("wrap_drained", {27'd0, count}, 32'd0);

    // Full with read+write, overflow, then flush with write pending
    for (int i = 0; i < 16; i++) op(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 8'h00);
    op(1'b1, 8'hD0, 1'b1, 1'b1, 8'hC0);
    check("full_rw_count", {27'd0, count}, 32'd16);
    check("full_rw_ovf", {31'd0, overflow}, 32'd0);
    op(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) op(1'b0, 8'h00, 1'b1, 1'b1, 8'hC1 + 8'(i));
    check("pre_flush_count", {27'd0, count}, 32'd10);
    check("pre_flush_ovf", {31'd0, overflow}, 32'd1);
    flush = 1'b1;
    op(1'b1, 8'hEE, 1'b0, 1'b0, 8'h00);
    flush = 1'b0;
    check("flush_count", {27'd0, count}, 32'd0);
    check("flush_empty", {31'd0, empty}, 32'd1);
    check("flush_ovf", {31'd0, overflow}, 32'd0);
    check("flush_addrs", {24'd0, addr_in, addr_out}, 32'd0);
    op(1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
    check("post_flush_empty", {31'd0, empty}, 32'd0);
`ifdef TRACKING_FIFO_SC_FWFT_EN
    check("fwft_first_word", {24'd0, data_out}, 32'h77);
`endif
    op(1'b0, 8'h00, 1'b1, 1'b1, 8'h77);

    // Reset mid-operation discards an in-flight write
    op(1'b1, 8'h31, 1'b0, 1'b0, 8'h00);
    op(1'b1, 8'h32, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    op(1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    check("midrst_count", {27'd0, count}, 32'd0);
    check("midrst_addrs", {24'd0, addr_in, addr_out}, 32'd0);
`ifndef TRACKING_FIFO_SC_FWFT_EN
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
`endif

    tick(); tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
